// File: rtl/int_ctrl_if.sv
// ============================================================================
// int_ctrl_if : CPU / config / interrupt-line bundle for int_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface int_ctrl_if #(
  parameter int NSRC = 8
);
  logic [NSRC-1:0] irq;
  logic            cfg_we;
  logic [1:0]      cfg_addr;
  logic [7:0]      cfg_wdata;
  logic [7:0]      cfg_rdata;
  logic            int_ack;
  logic            int_done;
  logic            INTin;
  logic [31:0]     INTnum;

  modport master (
    output irq, cfg_we, cfg_addr, cfg_wdata, int_ack, int_done,
    input  cfg_rdata, INTin, INTnum
  );

  modport slave (
    input  irq, cfg_we, cfg_addr, cfg_wdata, int_ack, int_done,
    output cfg_rdata, INTin, INTnum
  );
endinterface

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
// int_ctrl : edge-detecting, maskable, fixed-priority interrupt controller
// Rev 1.0
// ============================================================================
`default_nettype none

module int_ctrl #(
  parameter int NSRC = 8
) (
  input  logic        clk,
  input  logic        rst,
  int_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] c_ADDR_MASK   = 2'd0;
  localparam logic [1:0] c_ADDR_PEND   = 2'd1;
  localparam logic [1:0] c_ADDR_STATUS = 2'd2;

  state_t          state_q, state_d;
  logic [NSRC-1:0] irq_d_q;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [2:0]      cur_id_q, cur_id_d;

  logic [NSRC-1:0] w_edge;
  logic [NSRC-1:0] w_w1c;
  logic [NSRC-1:0] w_ack_clr;
  logic [NSRC-1:0] w_req_vec;
  logic [2:0]      w_winner;
  logic            w_take_ack;
  logic            w_intin;
  logic            w_service;

  assign w_edge     = bus.irq & ~irq_d_q;
  assign w_req_vec  = pend_q & mask_q;
  assign w_take_ack = (state_q == REQ) && bus.int_ack;
  assign w_w1c      = (bus.cfg_we && bus.cfg_addr == c_ADDR_PEND) ? bus.cfg_wdata : '0;
  assign w_ack_clr  = w_take_ack ? (NSRC'(1) << cur_id_q) : '0;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    w_winner = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_req_vec[i]) begin
        w_winner = 3'(i);
      end
    end
  end

  // A new edge beats any same-cycle clear so no event is lost.
  always_comb begin
    mask_d = mask_q;
    if (bus.cfg_we && bus.cfg_addr == c_ADDR_MASK) begin
      mask_d = bus.cfg_wdata;
    end
    pend_d = (pend_q & ~(w_w1c | w_ack_clr)) | w_edge;
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    unique case (state_q)
      IDLE: begin
        if (|w_req_vec) begin
          cur_id_d = w_winner;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.int_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      pend_q   <= '0;
      cur_id_q <= 3'd0;
      irq_d_q  <= bus.irq;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      cur_id_q <= cur_id_d;
      irq_d_q  <= bus.irq;
    end
  end

  assign w_intin   = (state_q == REQ);
  assign w_service = (state_q == SERVICE);

  assign bus.INTin  = w_intin;
  assign bus.INTnum = w_intin ? {28'd0, {1'b0, cur_id_q} + 4'd1} : 32'd0;

  always_comb begin
    bus.cfg_rdata = 8'h00;
    unique case (bus.cfg_addr)
      c_ADDR_MASK:   bus.cfg_rdata = mask_q;
      c_ADDR_PEND:   bus.cfg_rdata = pend_q;
      c_ADDR_STATUS: bus.cfg_rdata = {w_intin, w_service, 3'b000, cur_id_q};
      default:       bus.cfg_rdata = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
// tb_int_ctrl : scoreboard bench for int_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_int_ctrl;

  localparam int c_SEL_INTIN  = 0;
  localparam int c_SEL_INTNUM = 1;
  localparam int c_SEL_MASK   = 2;
  localparam int c_SEL_PEND   = 3;
  localparam int c_SEL_STATUS = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  int_ctrl_if #(.NSRC(8)) bus ();

  int_ctrl #(.NSRC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic read_reg(input logic [1:0] addr, output logic [7:0] data);
    bus.cfg_addr = addr;
    #1;
    data = bus.cfg_rdata;
  endtask

  task automatic drain();
    exp_t        e;
    logic [7:0]  rd;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        c_SEL_INTIN:  obs = {31'd0, bus.INTin};
        c_SEL_INTNUM: obs = bus.INTnum;
        c_SEL_MASK:   begin read_reg(2'd0, rd); obs = {24'd0, rd}; end
        c_SEL_PEND:   begin read_reg(2'd1, rd); obs = {24'd0, rd}; end
        default:      begin read_reg(2'd2, rd); obs = {24'd0, rd}; end
      endcase
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    bus.int_done = 1'b1;
    tick();
    bus.int_done = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.irq   = 8'h00;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = 2'd0;
    bus.cfg_wdata = 8'h00;
    bus.int_ack  = 1'b0;
    bus.int_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    expect_val("rst_intin",  c_SEL_INTIN,  32'd0);
    expect_val("rst_intnum", c_SEL_INTNUM, 32'd0);
    expect_val("rst_mask",   c_SEL_MASK,   32'h00);
    expect_val("rst_pend",   c_SEL_PEND,   32'h00);
    expect_val("rst_status", c_SEL_STATUS, 32'h00);
    drain();

    // Single source latency and STATUS encoding
    cfg_write(2'd0, 8'h02);
    bus.irq = 8'h02;
    tick();
    expect_val("lat_pend_k",   c_SEL_PEND,  32'h02);
    expect_val("lat_intin_k",  c_SEL_INTIN, 32'd0);
    drain();
    tick();
    expect_val("lat_intin_k1", c_SEL_INTIN,  32'd1);
    expect_val("lat_intnum",   c_SEL_INTNUM, 32'd2);
    expect_val("lat_status",   c_SEL_STATUS, 32'h81);
    drain();
    pulse_ack();
    expect_val("svc_intin",  c_SEL_INTIN,  32'd0);
    expect_val("svc_intnum", c_SEL_INTNUM, 32'd0);
    expect_val("svc_status", c_SEL_STATUS, 32'h41);
    expect_val("svc_pend",   c_SEL_PEND,   32'h00);
    drain();
    pulse_done();
    expect_val("done_status", c_SEL_STATUS, 32'h01);
    drain();
    bus.irq = 8'h00;
    tick();

    // Priority and back-to-back
    cfg_write(2'd0, 8'hFF);
    bus.irq = 8'h24;
    tick();
    expect_val("pri_pend", c_SEL_PEND, 32'h24);
    drain();
    tick();
    expect_val("pri_intnum", c_SEL_INTNUM, 32'd3);
    drain();
    pulse_ack();
    expect_val("pri_pend_ack", c_SEL_PEND,   32'h20);
    expect_val("pri_status",   c_SEL_STATUS, 32'h42);
    drain();
    pulse_done();
    expect_val("b2b_gap_intin", c_SEL_INTIN, 32'd0);
    drain();
    tick();
    expect_val("b2b_intin",  c_SEL_INTIN,  32'd1);
    expect_val("b2b_intnum", c_SEL_INTNUM, 32'd6);
    drain();
    pulse_ack();
    pulse_done();
    bus.irq = 8'h00;
    tick();
    expect_val("b2b_pend_end", c_SEL_PEND, 32'h00);
    drain();

    // Winner is locked once in REQ
    bus.irq = 8'h10;
    tick();
    tick();
    expect_val("lock_intnum0", c_SEL_INTNUM, 32'd5);
    drain();
    bus.irq = 8'h11;
    cfg_write(2'd0, 8'h00);
    expect_val("lock_intnum1", c_SEL_INTNUM, 32'd5);
    expect_val("lock_pend",    c_SEL_PEND,   32'h11);
    expect_val("lock_mask",    c_SEL_MASK,   32'h00);
    drain();
    cfg_write(2'd1, 8'h10);
    expect_val("lock_w1c_pend",   c_SEL_PEND,   32'h01);
    expect_val("lock_w1c_intnum", c_SEL_INTNUM, 32'd5);
    drain();
    pulse_ack();
    expect_val("lock_ack_status", c_SEL_STATUS, 32'h44);
    expect_val("lock_ack_pend",   c_SEL_PEND,   32'h01);
    drain();
    pulse_done();
    tick();
    expect_val("lock_masked_intin", c_SEL_INTIN, 32'd0);
    drain();
    bus.irq = 8'h00;
    cfg_write(2'd1, 8'h01);

    // int_done ignored in IDLE
    pulse_done();
    expect_val("idle_done_status", c_SEL_STATUS, 32'h04);
    expect_val("idle_done_pend",   c_SEL_PEND,   32'h00);
    drain();

    // Masked pend, set-wins-over-clear, plain W1C, dead addresses
    bus.irq = 8'h08;
    tick();
    expect_val("msk_pend",  c_SEL_PEND,  32'h08);
    expect_val("msk_intin", c_SEL_INTIN, 32'd0);
    drain();
    bus.irq = 8'h00;
    tick();
    bus.irq = 8'h08;
    cfg_write(2'd1, 8'h08);
    expect_val("setwins_pend", c_SEL_PEND, 32'h08);
    drain();
    cfg_write(2'd1, 8'h08);
    expect_val("w1c_pend", c_SEL_PEND, 32'h00);
    drain();
    cfg_write(2'd2, 8'hFF);
    cfg_write(2'd3, 8'hFF);
    expect_val("dead_wr_mask",   c_SEL_MASK,   32'h00);
    expect_val("dead_wr_status", c_SEL_STATUS, 32'h04);
    drain();
    bus.irq = 8'h00;
    tick();

    // Reset from SERVICE with pending sources held high
    cfg_write(2'd0, 8'hFF);
    bus.irq = 8'h30;
    tick();
    tick();
    expect_val("svc_setup_intnum", c_SEL_INTNUM, 32'd5);
    drain();
    pulse_ack();
    bus.irq = 8'h20;
    tick();
    bus.irq = 8'h30;
    tick();
    expect_val("svc_pend30", c_SEL_PEND, 32'h30);
    drain();
    pulse_ack();
    expect_val("svc_ack_status", c_SEL_STATUS, 32'h44);
    expect_val("svc_ack_pend",   c_SEL_PEND,   32'h30);
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_val("rst2_mask",   c_SEL_MASK,   32'h00);
    expect_val("rst2_pend",   c_SEL_PEND,   32'h00);
    expect_val("rst2_intin",  c_SEL_INTIN,  32'd0);
    expect_val("rst2_intnum", c_SEL_INTNUM, 32'd0);
    expect_val("rst2_status", c_SEL_STATUS, 32'h00);
    drain();
    cfg_write(2'd0, 8'hFF);
    tick();
    expect_val("held_pend",  c_SEL_PEND,  32'h00);
    expect_val("held_intin", c_SEL_INTIN, 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
